// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM encoding, the pipeline-control bundle and the fixed control patterns.
package hazard_control_unit_pkg;

    localparam int DEFAULT_REG_ADDR_WIDTH = 5;

    // FSM encoding kept as plain constants for compatibility with older blocks
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_BUSY = 1'b1;

    // Instruction word the IF/ID register loads when flushed (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One bundle holding every register-control output of the unit
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_bubble;
        logic mc_start;
    } pipe_ctrl_t;

    // Reset: freeze PC and pipeline regs, load NOP/bubbles into IF/ID and ID/EX
    localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                          id_ex_write: 1'b0, id_ex_flush: 1'b1,
                                          ex_mem_bubble: 1'b0, mc_start: 1'b0};

    // Normal flow: everything advances
    localparam pipe_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                        id_ex_write: 1'b1, id_ex_flush: 1'b0,
                                        ex_mem_bubble: 1'b0, mc_start: 1'b0};

    // Taken branch: advance, but discard the two younger instructions
    localparam pipe_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                           id_ex_write: 1'b1, id_ex_flush: 1'b1,
                                           ex_mem_bubble: 1'b0, mc_start: 1'b0};

    // Load-use: hold PC and IF/ID, push a bubble into ID/EX
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                             id_ex_write: 1'b1, id_ex_flush: 1'b1,
                                             ex_mem_bubble: 1'b0, mc_start: 1'b0};

    // First cycle of a multi-cycle op: kick the unit, freeze the front end
    localparam pipe_ctrl_t CTRL_MC_START = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                             id_ex_write: 1'b0, id_ex_flush: 1'b0,
                                             ex_mem_bubble: 1'b1, mc_start: 1'b1};

    // Waiting on the multi-cycle unit: freeze front end, bubble into MEM
    localparam pipe_ctrl_t CTRL_MC_HOLD = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                            id_ex_write: 1'b0, id_ex_flush: 1'b0,
                                            ex_mem_bubble: 1'b1, mc_start: 1'b0};

endpackage

// File: rtl/hazard_control_unit_mc_wait_timer.sv
// Wait timer for the multi-cycle handshake: counts busy cycles from zero and
// raises a terminal flag on the last cycle the controller is allowed to wait.
module mc_wait_timer
    import hazard_control_unit_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MC_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count busy cycles, parking on the terminal value until cleared
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// the start/done handshake with the multi-cycle EX unit, plus a saturating
// counter of cycles in which the PC was held.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int MC_TIMEOUT     = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs2,
    input  logic                      IF_ID_UsesRs2,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_Rd,
    input  logic                      ID_EX_MemRead,
    input  logic                      ID_EX_MultiCycle,
    input  logic                      EX_BranchTaken,
    input  logic                      MC_Done,
    output logic                      PC_Write,
    output logic                      IF_ID_Write,
    output logic                      IF_ID_Flush,
    output logic                      ID_EX_Write,
    output logic                      ID_EX_Flush,
    output logic                      EX_MEM_Bubble,
    output logic                      MC_Start,
    output logic                      MC_Error,
    output logic [CNT_WIDTH-1:0]      StallCount
);

    logic [0:0] state;
    logic [0:0] state_next;
    pipe_ctrl_t ctrl;
    logic       load_use;
    logic       mc_terminal;
    logic       mc_error_set;

    // The x0 destination never creates a real dependency, so it is excluded
    assign load_use = ID_EX_MemRead && (ID_EX_Rd != '0) &&
                      ((ID_EX_Rd == IF_ID_Rs1) ||
                       (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));

    mc_wait_timer #(
        .MC_TIMEOUT (MC_TIMEOUT)
    ) u_mc_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == ST_RUN),
        .enable   (state == ST_MC_BUSY),
        .terminal (mc_terminal)
    );

    // Pick the control pattern and next state; branch beats multi-cycle beats load-use
    always_comb begin
        ctrl         = CTRL_RUN;
        state_next   = state;
        mc_error_set = 1'b0;
        if (rst) begin
            ctrl       = CTRL_RESET;
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (EX_BranchTaken) begin
                        ctrl = CTRL_BRANCH;
                    end else if (ID_EX_MultiCycle) begin
                        ctrl       = CTRL_MC_START;
                        state_next = ST_MC_BUSY;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
                ST_MC_BUSY: begin
                    if (MC_Done) begin
                        ctrl       = CTRL_RUN;
                        state_next = ST_RUN;
                    end else if (mc_terminal) begin
                        ctrl         = CTRL_RUN;
                        state_next   = ST_RUN;
                        mc_error_set = 1'b1;
                    end else begin
                        ctrl = CTRL_MC_HOLD;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    assign PC_Write      = ctrl.pc_write;
    assign IF_ID_Write   = ctrl.if_id_write;
    assign IF_ID_Flush   = ctrl.if_id_flush;
    assign ID_EX_Write   = ctrl.id_ex_write;
    assign ID_EX_Flush   = ctrl.id_ex_flush;
    assign EX_MEM_Bubble = ctrl.ex_mem_bubble;
    assign MC_Start      = ctrl.mc_start;

    // FSM state register; reset aborts any pending handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Sticky timeout flag, only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            MC_Error <= 1'b0;
        end else if (mc_error_set) begin
            MC_Error <= 1'b1;
        end
    end

    // Count cycles with the PC held, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
        end else if (!ctrl.pc_write && (StallCount != {CNT_WIDTH{1'b1}})) begin
            StallCount <= StallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit. Each cycle the expected control
// bundle, error flag and stall count are queued with the stimulus and then
// popped and compared mid-cycle against the DUT.
module tb_hazard_control_unit;

    localparam int RW  = 5;
    localparam int TMO = 8;
    localparam int CW  = 4;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Bubble, MC_Start}
    localparam logic [6:0] C_RESET = 7'b0010100;
    localparam logic [6:0] C_RUN   = 7'b1101000;
    localparam logic [6:0] C_BR    = 7'b1111100;
    localparam logic [6:0] C_LU    = 7'b0001100;
    localparam logic [6:0] C_START = 7'b0000011;
    localparam logic [6:0] C_HOLD  = 7'b0000010;

    typedef struct {
        logic [6:0]    ctrl;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t expQ[$];

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rs1, rs2, rd;
    logic          usesRs2, memRead, multiCycle, branchTaken, mcDone;
    logic          pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemBubble, mcStart, mcError;
    logic [CW-1:0] stallCount;

    int checkCount = 0;
    int passCount  = 0;

    hazard_control_unit #(
        .REG_ADDR_WIDTH (RW),
        .MC_TIMEOUT     (TMO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_Rs1        (rs1),
        .IF_ID_Rs2        (rs2),
        .IF_ID_UsesRs2    (usesRs2),
        .ID_EX_Rd         (rd),
        .ID_EX_MemRead    (memRead),
        .ID_EX_MultiCycle (multiCycle),
        .EX_BranchTaken   (branchTaken),
        .MC_Done          (mcDone),
        .PC_Write         (pcWrite),
        .IF_ID_Write      (ifIdWrite),
        .IF_ID_Flush      (ifIdFlush),
        .ID_EX_Write      (idExWrite),
        .ID_EX_Flush      (idExFlush),
        .EX_MEM_Bubble    (exMemBubble),
        .MC_Start         (mcStart),
        .MC_Error         (mcError),
        .StallCount       (stallCount)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle, then clock
    task automatic applyStimulus(input string tag, input logic r,
                                 input logic [RW-1:0] s1, input logic [RW-1:0] s2, input logic u2,
                                 input logic [RW-1:0] d, input logic mr, input logic mc,
                                 input logic br, input logic dn,
                                 input logic [6:0] eCtrl, input logic eErr, input logic [CW-1:0] eCnt);
        exp_t e;
        rst = r; rs1 = s1; rs2 = s2; usesRs2 = u2; rd = d;
        memRead = mr; multiCycle = mc; branchTaken = br; mcDone = dn;
        e.ctrl = eCtrl; e.err = eErr; e.cnt = eCnt;
        expQ.push_back(e);
        #2;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_ctrl"}, 32'({pcWrite, ifIdWrite, ifIdFlush, idExWrite,
                                              idExFlush, exMemBubble, mcStart}), 32'(e.ctrl));
            checkOutput({tag, "_err"}, 32'(mcError), 32'(e.err));
            checkOutput({tag, "_cnt"}, 32'(stallCount), 32'(e.cnt));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; usesRs2 = 1'b0; rd = '0;
        memRead = 1'b0; multiCycle = 1'b0; branchTaken = 1'b0; mcDone = 1'b0;
        @(posedge clk);
        #1;

        // reset state and basic flow
        applyStimulus("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RESET, 0, 0);
        applyStimulus("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0);
        applyStimulus("lu_rs1",     0, 5, 0, 0, 5, 1, 0, 0, 0, C_LU,    0, 0);
        applyStimulus("after_lu",   0, 5, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 1);
        applyStimulus("lu_rd0",     0, 0, 0, 0, 0, 1, 0, 0, 0, C_RUN,   0, 1);
        applyStimulus("rs2_unused", 0, 3, 7, 0, 7, 1, 0, 0, 0, C_RUN,   0, 1);
        applyStimulus("lu_rs2",     0, 3, 7, 1, 7, 1, 0, 0, 0, C_LU,    0, 1);
        applyStimulus("br_over_lu", 0, 5, 0, 0, 5, 1, 0, 1, 0, C_BR,    0, 2);
        applyStimulus("idle2",      0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 2);

        // multi-cycle op, done 4 cycles after start; branch/load-use ignored while busy
        applyStimulus("mc_start",   0, 0, 0, 0, 0, 0, 1, 0, 0, C_START, 0, 2);
        applyStimulus("mc_hold1",   0, 0, 0, 0, 0, 0, 1, 0, 0, C_HOLD,  0, 3);
        applyStimulus("mc_hold_br", 0, 5, 0, 0, 5, 1, 1, 1, 0, C_HOLD,  0, 4);
        applyStimulus("mc_hold3",   0, 0, 0, 0, 0, 0, 1, 0, 0, C_HOLD,  0, 5);
        applyStimulus("mc_done",    0, 0, 0, 0, 0, 0, 1, 0, 1, C_RUN,   0, 6);
        applyStimulus("done_in_run",0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN,   0, 6);

        // done arriving on the 8th busy cycle wins over the timeout
        applyStimulus("mc8_start",  0, 0, 0, 0, 0, 0, 1, 0, 0, C_START, 0, 6);
        for (int i = 0; i < TMO - 1; i++) begin
            applyStimulus("mc8_hold", 0, 0, 0, 0, 0, 0, 1, 0, 0, C_HOLD, 0, CW'(7 + i));
        end
        applyStimulus("mc8_done",   0, 0, 0, 0, 0, 0, 1, 0, 1, C_RUN,   0, 14);
        applyStimulus("mc8_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 14);

        // timeout with no done; counter saturates at all-ones
        applyStimulus("to_start",   0, 0, 0, 0, 0, 0, 1, 0, 0, C_START, 0, 14);
        for (int i = 0; i < TMO - 1; i++) begin
            applyStimulus("to_hold", 0, 0, 0, 0, 0, 0, 1, 0, 0, C_HOLD, 0, 15);
        end
        applyStimulus("to_release", 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RUN,   0, 15);
        applyStimulus("err_set",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   1, 15);
        applyStimulus("sat_lu",     0, 9, 0, 0, 9, 1, 0, 0, 0, C_LU,    1, 15);
        applyStimulus("err_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   1, 15);

        // reset in the 2nd busy cycle aborts the handshake
        applyStimulus("rr_start",   0, 0, 0, 0, 0, 0, 1, 0, 0, C_START, 1, 15);
        applyStimulus("rr_hold",    0, 0, 0, 0, 0, 0, 1, 0, 0, C_HOLD,  1, 15);
        applyStimulus("rr_reset",   1, 0, 0, 0, 0, 0, 1, 0, 0, C_RESET, 1, 15);
        applyStimulus("rr_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0);

        // shortest op: done one cycle after start
        applyStimulus("n1_start",   0, 0, 0, 0, 0, 0, 1, 0, 0, C_START, 0, 0);
        applyStimulus("n1_done",    0, 0, 0, 0, 0, 0, 1, 0, 1, C_RUN,   0, 1);
        applyStimulus("n1_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
